cp0_timer_unit: RTL and testbench

CP0_TIMER_UNIT -- requirements
Module: cp0_timer_unit

---
 rtl/cp0_pkg.sv | 43 ++++
 rtl/cp0_timer_unit_channel.sv | 75 +++++++
 rtl/cp0_timer_unit.sv | 156 +++++++++++++++
 tb/tb_cp0_timer_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register address/sel constants, request payloads,
// the TimerCtl layout and a small elaboration-time helper.
package cp0_pkg;

    localparam int unsigned CP0_ADDR_W  = 5;
    localparam int unsigned CP0_SEL_W   = 3;
    localparam int unsigned CP0_DATA_W  = 32;
    localparam int unsigned CTL_FIELD_W = 8;
    localparam int unsigned MAX_TIMERS  = 4;
    localparam int unsigned MAX_DIV     = 256;

    localparam logic [CP0_ADDR_W-1:0] CP0_COUNT    = 5'd9;
    localparam logic [CP0_ADDR_W-1:0] CP0_COMPARE  = 5'd11;
    localparam logic [CP0_ADDR_W-1:0] CP0_TIMERCTL = 5'd22;

    // Period[k] lives at (CP0_COMPARE, PERIOD_SEL_BASE + k)
    localparam int unsigned PERIOD_SEL_BASE = 4;

    typedef struct packed {
        logic [CP0_ADDR_W-1:0] raddr;
        logic [CP0_SEL_W-1:0]  rsel;
    } cp0_rreq_t;

    typedef struct packed {
        logic                  we;
        logic [CP0_ADDR_W-1:0] waddr;
        logic [CP0_SEL_W-1:0]  wsel;
        logic [CP0_DATA_W-1:0] wrdata;
    } cp0_wreq_t;

    // TimerCtl word: [31:24] reserved, [23:16] pending, [15:8] periodic, [7:0] enable
    typedef struct packed {
        logic [CTL_FIELD_W-1:0] rsvd;
        logic [CTL_FIELD_W-1:0] pending;
        logic [CTL_FIELD_W-1:0] periodic;
        logic [CTL_FIELD_W-1:0] enable;
    } timer_ctl_t;

    function automatic logic is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/cp0_timer_unit_channel.sv
// One compare channel: Compare/Period registers, enable/periodic/pending
// state and the match/reload logic.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   tick                  Count advances this cycle (already suppressed on Count writes)
//   count_inc             Count + 1, the value Count takes on this tick
//   compare_we, period_we write strobes for Compare[k] / Period[k]
//   ctl_we                TimerCtl write strobe
//   wrdata                write data
//   ctl_enable/periodic/clr  this channel's bits of the TimerCtl write data
//   compare, period, enable, periodic, pending  register state for reads
//   timer_int             pending & enable
module cp0_timer_channel
    import cp0_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [CP0_DATA_W-1:0] count_inc,
    input  logic                  compare_we,
    input  logic                  period_we,
    input  logic                  ctl_we,
    input  logic [CP0_DATA_W-1:0] wrdata,
    input  logic                  ctl_enable,
    input  logic                  ctl_periodic,
    input  logic                  ctl_clr,
    output logic [CP0_DATA_W-1:0] compare,
    output logic [CP0_DATA_W-1:0] period,
    output logic                  enable,
    output logic                  periodic,
    output logic                  pending,
    output logic                  timer_int
);

    logic match;

    // Compare against Count+1 so pending lands on the edge Count reaches Compare
    assign match     = tick && (count_inc == compare);
    assign timer_int = pending & enable;

    // Channel state; a Compare write beats a same-cycle match, match beats W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            compare  <= '0;
            period   <= '0;
            enable   <= 1'b0;
            periodic <= 1'b0;
            pending  <= 1'b0;
        end else begin
            if (compare_we) begin
                compare <= wrdata;
            end else if (match && periodic) begin
                compare <= compare + period;
            end

            if (period_we) begin
                period <= wrdata;
            end

            if (ctl_we) begin
                enable   <= ctl_enable;
                periodic <= ctl_periodic;
            end

            if (compare_we) begin
                pending <= 1'b0;
            end else if (match) begin
                pending <= 1'b1;
            end else if (ctl_we && ctl_clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cp0_timer_unit.sv
// CP0 timer block: free-running prescaled Count plus N_TIMERS compare
// channels with optional periodic reload, exposed as CP0 registers.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   cp0_rreq     read address/sel; cp0_rddata is combinational from register state
//   cp0_wreq     write request (we, waddr, wsel, wrdata)
//   count_halt   freezes Count and the prescaler
//   timer_int    per-channel interrupt (pending & enable)
//   timer_irq    OR of timer_int, feeds Cause.IP7
module cp0_timer_unit
    import cp0_pkg::*;
#(
    parameter int unsigned N_TIMERS  = 2,
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  cp0_rreq_t             cp0_rreq,
    output logic [CP0_DATA_W-1:0] cp0_rddata,
    input  cp0_wreq_t             cp0_wreq,
    input  logic                  count_halt,
    output logic [N_TIMERS-1:0]   timer_int,
    output logic                  timer_irq
);

    localparam int unsigned PRE_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    // Reject illegal configurations at elaboration
    if (N_TIMERS < 1 || N_TIMERS > MAX_TIMERS) begin : g_bad_n_timers
        $error("cp0_timer_unit: N_TIMERS must be in 1..4");
    end
    if (!is_pow2(COUNT_DIV) || COUNT_DIV > MAX_DIV) begin : g_bad_count_div
        $error("cp0_timer_unit: COUNT_DIV must be a power of two in 1..256");
    end

    logic [CP0_DATA_W-1:0] count;
    logic [CP0_DATA_W-1:0] count_inc;
    logic                  count_we;
    logic                  ctl_we;
    logic                  compare_addr;
    logic                  tick_raw;
    logic                  tick;

    logic [CP0_DATA_W-1:0] compare_arr [N_TIMERS];
    logic [CP0_DATA_W-1:0] period_arr  [N_TIMERS];
    logic [N_TIMERS-1:0]   en_v;
    logic [N_TIMERS-1:0]   per_v;
    logic [N_TIMERS-1:0]   pend_v;
    timer_ctl_t            ctl_rd;

    // Write decode
    assign count_we     = cp0_wreq.we && (cp0_wreq.waddr == CP0_COUNT) && (cp0_wreq.wsel == '0);
    assign ctl_we       = cp0_wreq.we && (cp0_wreq.waddr == CP0_TIMERCTL) && (cp0_wreq.wsel == '0);
    assign compare_addr = cp0_wreq.we && (cp0_wreq.waddr == CP0_COMPARE);

    // Prescaler; a Count write restarts it and swallows that cycle's tick
    if (COUNT_DIV == 1) begin : g_div1
        assign tick_raw = !count_halt;
    end else begin : g_divn
        localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(COUNT_DIV - 1);
        logic [PRE_W-1:0] prescale;

        assign tick_raw = (prescale == PRE_MAX) && !count_halt;

        always_ff @(posedge clk) begin
            if (rst || count_we) begin
                prescale <= '0;
            end else if (!count_halt) begin
                prescale <= prescale + PRE_W'(1);
            end
        end
    end

    assign tick      = tick_raw && !count_we;
    assign count_inc = count + CP0_DATA_W'(1);

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (count_we) begin
            count <= cp0_wreq.wrdata;
        end else if (tick) begin
            count <= count_inc;
        end
    end

    // Compare channels
    for (genvar k = 0; k < N_TIMERS; k++) begin : g_ch
        logic compare_we;
        logic period_we;

        assign compare_we = compare_addr && (cp0_wreq.wsel == CP0_SEL_W'(k));
        assign period_we  = compare_addr && (cp0_wreq.wsel == CP0_SEL_W'(PERIOD_SEL_BASE + k));

        cp0_timer_channel u_channel (
            .clk          (clk),
            .rst          (rst),
            .tick         (tick),
            .count_inc    (count_inc),
            .compare_we   (compare_we),
            .period_we    (period_we),
            .ctl_we       (ctl_we),
            .wrdata       (cp0_wreq.wrdata),
            .ctl_enable   (cp0_wreq.wrdata[k]),
            .ctl_periodic (cp0_wreq.wrdata[CTL_FIELD_W + k]),
            .ctl_clr      (cp0_wreq.wrdata[2*CTL_FIELD_W + k]),
            .compare      (compare_arr[k]),
            .period       (period_arr[k]),
            .enable       (en_v[k]),
            .periodic     (per_v[k]),
            .pending      (pend_v[k]),
            .timer_int    (timer_int[k])
        );
    end

    assign timer_irq = |timer_int;

    // TimerCtl read image
    always_comb begin
        ctl_rd          = '0;
        ctl_rd.enable   = CTL_FIELD_W'(en_v);
        ctl_rd.periodic = CTL_FIELD_W'(per_v);
        ctl_rd.pending  = CTL_FIELD_W'(pend_v);
    end

    // Combinational read mux; unmapped address/sel reads zero
    always_comb begin
        cp0_rddata = '0;
        case (cp0_rreq.raddr)
            CP0_COUNT: begin
                if (cp0_rreq.rsel == '0) begin
                    cp0_rddata = count;
                end
            end
            CP0_COMPARE: begin
                for (int k = 0; k < N_TIMERS; k++) begin
                    if (cp0_rreq.rsel == CP0_SEL_W'(k)) begin
                        cp0_rddata = compare_arr[k];
                    end
                    if (cp0_rreq.rsel == CP0_SEL_W'(PERIOD_SEL_BASE + k)) begin
                        cp0_rddata = period_arr[k];
                    end
                end
            end
            CP0_TIMERCTL: begin
                if (cp0_rreq.rsel == '0) begin
                    cp0_rddata = ctl_rd;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cp0_timer_unit.sv
// Directed bench for cp0_timer_unit: a COUNT_DIV=2 / 2-channel instance and a
// COUNT_DIV=1 / 1-channel instance for the wrap-around cases. Expected values
// are queued when a step is driven and popped when the DUT value is sampled.
module tb_cp0_timer_unit;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    cp0_rreq_t   rreq0, rreq1;
    cp0_wreq_t   wreq0, wreq1;
    logic [31:0] rdata0, rdata1;
    logic        halt0, halt1;
    logic [1:0]  tint0;
    logic [0:0]  tint1;
    logic        irq0, irq1;

    always #5 clk = ~clk;

    cp0_timer_unit #(.N_TIMERS(2), .COUNT_DIV(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .cp0_rreq   (rreq0),
        .cp0_rddata (rdata0),
        .cp0_wreq   (wreq0),
        .count_halt (halt0),
        .timer_int  (tint0),
        .timer_irq  (irq0)
    );

    cp0_timer_unit #(.N_TIMERS(1), .COUNT_DIV(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .cp0_rreq   (rreq1),
        .cp0_rddata (rdata1),
        .cp0_wreq   (wreq1),
        .count_halt (halt1),
        .timer_int  (tint1),
        .timer_irq  (irq1)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    task automatic expect_val(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        e = sb.pop_front();
        total++;
        assert (obs === e.exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", e.tag, obs, e.exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input bit which, input logic [4:0] a, input logic [2:0] s,
                      input logic [31:0] d);
        cp0_wreq_t w;
        w.we     = 1'b1;
        w.waddr  = a;
        w.wsel   = s;
        w.wrdata = d;
        if (which) wreq1 = w;
        else       wreq0 = w;
        @(posedge clk);
        #1;
        wreq0.we = 1'b0;
        wreq1.we = 1'b0;
    endtask

    task automatic chk_rd(input bit which, input string tag, input logic [4:0] a,
                          input logic [2:0] s, input logic [31:0] exp);
        logic [31:0] obs;
        expect_val(tag, exp);
        if (which) begin
            rreq1.raddr = a;
            rreq1.rsel  = s;
        end else begin
            rreq0.raddr = a;
            rreq0.rsel  = s;
        end
        #1;
        obs = which ? rdata1 : rdata0;
        check(obs);
    endtask

    task automatic chk_sig(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        expect_val(tag, exp);
        check(obs);
    endtask

    // Bounded wait for timer_int[ch] of the main instance
    task automatic wait_int(input int ch, input int bound, input string tag);
        int n = 0;
        while (!tint0[ch] && n < bound) begin
            step(1);
            n++;
        end
        chk_sig(tag, 32'(tint0[ch]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        rreq0 = '0;
        rreq1 = '0;
        wreq0 = '0;
        wreq1 = '0;
        halt0 = 1'b0;
        halt1 = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);

        // Reset state
        chk_rd(0, "rst_count", CP0_COUNT, 3'd0, 32'd0);
        chk_rd(0, "rst_cmp0", CP0_COMPARE, 3'd0, 32'd0);
        chk_rd(0, "rst_per1", CP0_COMPARE, 3'd5, 32'd0);
        chk_rd(0, "rst_ctl", CP0_TIMERCTL, 3'd0, 32'd0);
        chk_sig("rst_int", 32'(tint0), 32'd0);
        chk_sig("rst_irq", 32'(irq0), 32'd0);

        // Unmapped writes are dropped, unmapped reads are zero
        wr(0, CP0_COMPARE, 3'd2, 32'hDEAD_BEEF);
        wr(0, 5'd10, 3'd0, 32'h1234_5678);
        chk_rd(0, "unmap_sel2", CP0_COMPARE, 3'd2, 32'd0);
        chk_rd(0, "unmap_addr10", 5'd10, 3'd0, 32'd0);
        chk_rd(0, "unmap_cmp0", CP0_COMPARE, 3'd0, 32'd0);

        // One-shot match: Count=10, Compare0=13, enable ch0
        wr(0, CP0_COUNT, 3'd0, 32'd10);
        wr(0, CP0_COMPARE, 3'd0, 32'd13);
        wr(0, CP0_TIMERCTL, 3'd0, 32'h0000_0001);
        chk_rd(0, "os_count_e2", CP0_COUNT, 3'd0, 32'd11);
        step(3);
        chk_rd(0, "os_count_e5", CP0_COUNT, 3'd0, 32'd12);
        chk_sig("os_int_e5", 32'(tint0), 32'd0);
        step(1);
        chk_rd(0, "os_count_e6", CP0_COUNT, 3'd0, 32'd13);
        chk_sig("os_int_e6", 32'(tint0), 32'd1);
        chk_sig("os_irq_e6", 32'(irq0), 32'd1);
        chk_rd(0, "os_ctl_e6", CP0_TIMERCTL, 3'd0, 32'h0001_0001);
        wr(0, CP0_TIMERCTL, 3'd0, 32'h0001_0001);
        chk_sig("os_w1c_int", 32'(tint0), 32'd0);

        // Periodic reload on channel 1
        wr(0, CP0_COMPARE, 3'd1, 32'd100);
        wr(0, CP0_COMPARE, 3'd5, 32'd50);
        wr(0, CP0_TIMERCTL, 3'd0, 32'h0000_0203);
        wr(0, CP0_COUNT, 3'd0, 32'd95);
        wait_int(1, 300, "per_first_int");
        chk_rd(0, "per_count100", CP0_COUNT, 3'd0, 32'd100);
        chk_rd(0, "per_cmp150", CP0_COMPARE, 3'd1, 32'd150);
        chk_rd(0, "per_ctl1", CP0_TIMERCTL, 3'd0, 32'h0002_0203);
        wr(0, CP0_TIMERCTL, 3'd0, 32'h0002_0203);
        chk_rd(0, "per_w1c", CP0_TIMERCTL, 3'd0, 32'h0000_0203);
        wait_int(1, 300, "per_second_int");
        chk_rd(0, "per_count150", CP0_COUNT, 3'd0, 32'd150);
        chk_rd(0, "per_cmp200", CP0_COMPARE, 3'd1, 32'd200);

        // Compare write in the match cycle wins: no pending
        wr(0, CP0_TIMERCTL, 3'd0, 32'h0003_0001);
        wr(0, CP0_COMPARE, 3'd0, 32'd20);
        wr(0, CP0_COUNT, 3'd0, 32'd18);
        step(3);
        wr(0, CP0_COMPARE, 3'd0, 32'h0000_1000);
        chk_rd(0, "sim_cmp_count", CP0_COUNT, 3'd0, 32'd20);
        chk_rd(0, "sim_cmp_val", CP0_COMPARE, 3'd0, 32'h0000_1000);
        chk_rd(0, "sim_cmp_ctl", CP0_TIMERCTL, 3'd0, 32'h0000_0001);
        chk_sig("sim_cmp_int", 32'(tint0), 32'd0);

        // W1C in the match cycle loses: pending stays set
        wr(0, CP0_COMPARE, 3'd0, 32'd24);
        wr(0, CP0_COUNT, 3'd0, 32'd22);
        step(3);
        wr(0, CP0_TIMERCTL, 3'd0, 32'h0001_0001);
        chk_rd(0, "sim_w1c_count", CP0_COUNT, 3'd0, 32'd24);
        chk_rd(0, "sim_w1c_ctl", CP0_TIMERCTL, 3'd0, 32'h0001_0001);
        chk_sig("sim_w1c_int", 32'(tint0), 32'd1);

        // Halt freezes Count and pending but writes still land
        halt0 = 1'b1;
        step(10);
        chk_rd(0, "halt_count", CP0_COUNT, 3'd0, 32'd24);
        wr(0, CP0_COMPARE, 3'd1, 32'h0000_0055);
        chk_rd(0, "halt_wr", CP0_COMPARE, 3'd1, 32'h0000_0055);
        chk_rd(0, "halt_count2", CP0_COUNT, 3'd0, 32'd24);
        chk_rd(0, "halt_ctl", CP0_TIMERCTL, 3'd0, 32'h0001_0001);
        halt0 = 1'b0;

        // Disabled channel still sets pending; enabling raises the interrupt
        wr(0, CP0_TIMERCTL, 3'd0, 32'h0001_0000);
        wr(0, CP0_COMPARE, 3'd0, 32'd40);
        wr(0, CP0_COUNT, 3'd0, 32'd38);
        step(4);
        chk_rd(0, "dis_count", CP0_COUNT, 3'd0, 32'd40);
        chk_rd(0, "dis_ctl", CP0_TIMERCTL, 3'd0, 32'h0001_0000);
        chk_sig("dis_int", 32'(tint0), 32'd0);
        chk_sig("dis_irq", 32'(irq0), 32'd0);
        wr(0, CP0_TIMERCTL, 3'd0, 32'h0000_0001);
        chk_sig("en_int", 32'(tint0), 32'd1);
        chk_sig("en_irq", 32'(irq0), 32'd1);

        // Reset one cycle before a match
        wr(0, CP0_TIMERCTL, 3'd0, 32'h0001_0001);
        wr(0, CP0_COMPARE, 3'd0, 32'd50);
        wr(0, CP0_COUNT, 3'd0, 32'd48);
        step(3);
        chk_rd(0, "mr_pre_count", CP0_COUNT, 3'd0, 32'd49);
        rst = 1'b1;
        step(1);
        chk_rd(0, "mr_count", CP0_COUNT, 3'd0, 32'd0);
        chk_rd(0, "mr_cmp0", CP0_COMPARE, 3'd0, 32'd0);
        chk_rd(0, "mr_per1", CP0_COMPARE, 3'd5, 32'd0);
        chk_rd(0, "mr_ctl", CP0_TIMERCTL, 3'd0, 32'd0);
        chk_sig("mr_int", 32'(tint0), 32'd0);
        chk_sig("mr_irq", 32'(irq0), 32'd0);
        rst = 1'b0;
        step(1);
        chk_sig("mr_post_int", 32'(tint0), 32'd0);
        chk_rd(0, "mr_post_count", CP0_COUNT, 3'd0, 32'd0);

        // Wrap-around with COUNT_DIV=1
        wr(1, CP0_COMPARE, 3'd0, 32'h0000_0001);
        wr(1, CP0_TIMERCTL, 3'd0, 32'h0000_0001);
        wr(1, CP0_COUNT, 3'd0, 32'hFFFF_FFFE);
        step(2);
        chk_rd(1, "wrap_count0", CP0_COUNT, 3'd0, 32'd0);
        chk_sig("wrap_int_early", 32'(tint1), 32'd0);
        step(1);
        chk_rd(1, "wrap_count1", CP0_COUNT, 3'd0, 32'd1);
        chk_sig("wrap_int", 32'(tint1), 32'd1);
        chk_sig("wrap_irq", 32'(irq1), 32'd1);
        chk_rd(1, "wrap_unmap_sel1", CP0_COMPARE, 3'd1, 32'd0);

        // Periodic reload wrapping modulo 2^32
        wr(1, CP0_TIMERCTL, 3'd0, 32'h0001_0101);
        wr(1, CP0_COMPARE, 3'd4, 32'h0000_0020);
        wr(1, CP0_COMPARE, 3'd0, 32'hFFFF_FFF0);
        wr(1, CP0_COUNT, 3'd0, 32'hFFFF_FFEE);
        step(1);
        chk_sig("rw_int_early", 32'(tint1), 32'd0);
        step(1);
        chk_rd(1, "rw_count", CP0_COUNT, 3'd0, 32'hFFFF_FFF0);
        chk_rd(1, "rw_cmp", CP0_COMPARE, 3'd0, 32'h0000_0010);
        chk_sig("rw_int", 32'(tint1), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
